payload_ram_loader: RTL and testbench

PAYLOAD_RAM_LOADER -- requirements
Module: payload_ram_loader

---
 rtl/eth_pkg.sv | 17 +
 rtl/payload_ram_loader.sv | 184 ++++++++++++++++++
 tb/tb_payload_ram_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/UDP definitions for the payload RAM loader.
package eth_pkg;

  // Loader control states: message preload, receiver pass-through, and
  // pass-through while waiting for the receiver to go idle before reloading.
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    PASS = 2'd1,
    WAIT = 2'd2
  } load_state_e;

  localparam int unsigned UDP_HDR_BYTES = 8;
  localparam int unsigned IP_HDR_BYTES  = 20;
  localparam int unsigned LEN_W         = 16;
  localparam int unsigned CNT_W         = 8;

endpackage

// File: rtl/payload_ram_loader.sv
// Payload RAM loader: writes a fixed message into RAM port A after reset or on
// request, otherwise forwards receiver payload writes, and supplies the UDP/IP
// lengths the transmitter should use.
module payload_ram_loader
  import eth_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned MSG_WORDS = 5,
  parameter int unsigned BASE_ADDR = 1,
  parameter logic [MSG_WORDS*DATA_W-1:0] MSG =
    (MSG_WORDS*DATA_W)'("HELLO ALINX AX7103\r\n")
) (
  input  logic              gmii_rx_clk,
  input  logic              reset_n,
  input  logic              load_req,
  input  logic              rx_wr_en,
  input  logic [ADDR_W-1:0] rx_wr_addr,
  input  logic [DATA_W-1:0] rx_wr_data,
  input  logic              rx_frame_active,
  input  logic              data_receive,
  input  logic [LEN_W-1:0]  rx_data_length,
  input  logic [LEN_W-1:0]  rx_total_length,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic [LEN_W-1:0]  tx_data_length,
  output logic [LEN_W-1:0]  tx_total_length,
  output logic              loading,
  output logic              load_done,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int unsigned MSG_BITS      = MSG_WORDS * DATA_W;
  localparam int unsigned SEL_W         = (MSG_BITS > 1) ? $clog2(MSG_BITS) : 1;
  localparam int unsigned IDX_W         = $clog2(MSG_WORDS + 1);
  localparam int unsigned DEF_DATA_LEN  = MSG_BITS / 8 + UDP_HDR_BYTES;
  localparam int unsigned DEF_TOTAL_LEN = DEF_DATA_LEN + IP_HDR_BYTES;

  localparam logic [LEN_W-1:0] DEF_DATA_LEN_V  = LEN_W'(DEF_DATA_LEN);
  localparam logic [LEN_W-1:0] DEF_TOTAL_LEN_V = LEN_W'(DEF_TOTAL_LEN);
  localparam logic [IDX_W-1:0] END_IDX         = IDX_W'(MSG_WORDS);

  // Elaboration-time parameter legality.
  if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_bad_data_w
    $error("payload_ram_loader: DATA_W must be a non-zero multiple of 8");
  end
  if (MSG_WORDS == 0) begin : g_bad_msg_words
    $error("payload_ram_loader: MSG_WORDS must be at least 1");
  end
  if (DEF_TOTAL_LEN > 65535) begin : g_bad_len
    $error("payload_ram_loader: default IP total length exceeds 16 bits");
  end
  if ((64'(BASE_ADDR) + 64'(MSG_WORDS)) > (64'd1 << ADDR_W)) begin : g_bad_addr
    $error("payload_ram_loader: message does not fit in the RAM address space");
  end

  load_state_e       state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              ram_we_nxt;
  logic [ADDR_W-1:0] ram_addr_nxt;
  logic [DATA_W-1:0] ram_din_nxt;
  logic              loading_nxt;
  logic              load_done_nxt;
  logic [CNT_W-1:0]  drop_cnt_nxt;
  logic              rx_idle;
  logic [SEL_W-1:0]  word_lsb;
  logic [DATA_W-1:0] msg_word;

  // Receiver is quiet enough to let the RAM port be taken over for a reload.
  assign rx_idle = !rx_frame_active && !rx_wr_en;

  // Select message word idx; word 0 sits in the most-significant bits of MSG.
  always_comb begin
    word_lsb = '0;
    if (idx < END_IDX) begin
      word_lsb = SEL_W'((MSG_WORDS - 1 - 32'(idx)) * DATA_W);
    end
    msg_word = MSG[word_lsb +: DATA_W];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    ram_we_nxt    = 1'b0;
    ram_addr_nxt  = ram_addr;
    ram_din_nxt   = ram_din;
    loading_nxt   = 1'b0;
    load_done_nxt = load_done;
    drop_cnt_nxt  = drop_cnt;

    case (state)
      LOAD: begin
        if (idx < END_IDX) begin
          ram_we_nxt   = 1'b1;
          ram_addr_nxt = ADDR_W'(BASE_ADDR + 32'(idx));
          ram_din_nxt  = msg_word;
          loading_nxt  = 1'b1;
          idx_nxt      = idx + 1'b1;
        end else begin
          state_nxt     = PASS;
          load_done_nxt = 1'b1;
          idx_nxt       = '0;
        end
        // Receiver writes cannot share the port during a preload.
        if (rx_wr_en && (drop_cnt != {CNT_W{1'b1}})) begin
          drop_cnt_nxt = drop_cnt + 1'b1;
        end
      end
      PASS: begin
        ram_we_nxt   = rx_wr_en;
        ram_addr_nxt = rx_wr_addr;
        ram_din_nxt  = rx_wr_data;
        if (load_req) begin
          if (rx_idle) begin
            state_nxt = LOAD;
            idx_nxt   = '0;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        ram_we_nxt   = rx_wr_en;
        ram_addr_nxt = rx_wr_addr;
        ram_din_nxt  = rx_wr_data;
        if (rx_idle) begin
          state_nxt = LOAD;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = LOAD;
        idx_nxt   = '0;
      end
    endcase
  end

  // State and word-index registers.
  always_ff @(posedge gmii_rx_clk) begin
    if (!reset_n) begin
      state <= LOAD;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // RAM port and status output registers.
  always_ff @(posedge gmii_rx_clk) begin
    if (!reset_n) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      loading   <= 1'b0;
      load_done <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      ram_we    <= ram_we_nxt;
      ram_addr  <= ram_addr_nxt;
      ram_din   <= ram_din_nxt;
      loading   <= loading_nxt;
      load_done <= load_done_nxt;
      drop_cnt  <= drop_cnt_nxt;
    end
  end

  // Echo received lengths, else advertise the preloaded message lengths.
  always_ff @(posedge gmii_rx_clk) begin
    if (!reset_n) begin
      tx_data_length  <= DEF_DATA_LEN_V;
      tx_total_length <= DEF_TOTAL_LEN_V;
    end else if (data_receive) begin
      tx_data_length  <= rx_data_length;
      tx_total_length <= rx_total_length;
    end else begin
      tx_data_length  <= DEF_DATA_LEN_V;
      tx_total_length <= DEF_TOTAL_LEN_V;
    end
  end

endmodule

// File: tb/tb_payload_ram_loader.sv
// Self-checking bench for payload_ram_loader: default-message instance plus a
// 300-word instance for the drop-counter saturation case.
module tb_payload_ram_loader;

  localparam int unsigned N      = 5;
  localparam int unsigned BASE   = 1;
  localparam int unsigned DEF_DL = 5 * 4 + 8;
  localparam int unsigned DEF_TL = DEF_DL + 20;

  localparam int unsigned BIG_N      = 300;
  localparam int unsigned BIG_BITS   = BIG_N * 32;
  localparam int unsigned BIG_DEF_DL = BIG_N * 4 + 8;
  localparam int unsigned BIG_DEF_TL = BIG_DEF_DL + 20;

  function automatic logic [BIG_BITS-1:0] big_msg();
    logic [BIG_BITS-1:0] v = '0;
    for (int i = 0; i < BIG_N; i++) begin
      v = (v << 32) | BIG_BITS'(32'hC0DE0000 | 32'(i));
    end
    return v;
  endfunction

  localparam logic [BIG_BITS-1:0] BIG_MSG = big_msg();

  logic [31:0] exp_words [5] = '{32'h48454C4C, 32'h4F20414C, 32'h494E5820,
                                 32'h41583731, 32'h30330D0A};

  logic        clk;
  logic        reset_n, load_req, rx_wr_en, rx_frame_active, data_receive;
  logic [8:0]  rx_wr_addr;
  logic [31:0] rx_wr_data;
  logic [15:0] rx_data_length, rx_total_length;
  logic        ram_we, loading, load_done;
  logic [8:0]  ram_addr;
  logic [31:0] ram_din;
  logic [15:0] tx_data_length, tx_total_length;
  logic [7:0]  drop_cnt;

  logic        b_reset_n, b_load_req, b_wr_en;
  logic        b_ram_we, b_loading, b_load_done;
  logic [8:0]  b_ram_addr;
  logic [31:0] b_ram_din;
  logic [15:0] b_tx_data_length, b_tx_total_length;
  logic [7:0]  b_drop_cnt;

  int   checks   = 0;
  int   failures = 0;
  int   m_drops  = 0;
  logic m_done   = 1'b0;

  payload_ram_loader dut (
    .gmii_rx_clk    (clk),
    .reset_n        (reset_n),
    .load_req       (load_req),
    .rx_wr_en       (rx_wr_en),
    .rx_wr_addr     (rx_wr_addr),
    .rx_wr_data     (rx_wr_data),
    .rx_frame_active(rx_frame_active),
    .data_receive   (data_receive),
    .rx_data_length (rx_data_length),
    .rx_total_length(rx_total_length),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .tx_data_length (tx_data_length),
    .tx_total_length(tx_total_length),
    .loading        (loading),
    .load_done      (load_done),
    .drop_cnt       (drop_cnt)
  );

  payload_ram_loader #(
    .DATA_W   (32),
    .ADDR_W   (9),
    .MSG_WORDS(BIG_N),
    .BASE_ADDR(1),
    .MSG      (BIG_MSG)
  ) dut_big (
    .gmii_rx_clk    (clk),
    .reset_n        (b_reset_n),
    .load_req       (b_load_req),
    .rx_wr_en       (b_wr_en),
    .rx_wr_addr     (rx_wr_addr),
    .rx_wr_data     (rx_wr_data),
    .rx_frame_active(rx_frame_active),
    .data_receive   (data_receive),
    .rx_data_length (rx_data_length),
    .rx_total_length(rx_total_length),
    .ram_we         (b_ram_we),
    .ram_addr       (b_ram_addr),
    .ram_din        (b_ram_din),
    .tx_data_length (b_tx_data_length),
    .tx_total_length(b_tx_total_length),
    .loading        (b_loading),
    .load_done      (b_load_done),
    .drop_cnt       (b_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_len_rand();
    data_receive    = 1'($urandom_range(0, 1));
    rx_data_length  = 16'($urandom);
    rx_total_length = 16'($urandom);
  endtask

  // Advance one clock and check the length echo against the inputs just sampled.
  task automatic tick_check(input string tag);
    logic [15:0] e_dl, e_tl;
    e_dl = (reset_n && data_receive) ? rx_data_length  : 16'(DEF_DL);
    e_tl = (reset_n && data_receive) ? rx_total_length : 16'(DEF_TL);
    @(posedge clk);
    #1;
    chk({tag, "_dlen"}, 32'(tx_data_length), 32'(e_dl));
    chk({tag, "_tlen"}, 32'(tx_total_length), 32'(e_tl));
  endtask

  task automatic idle_inputs();
    load_req        = 1'b0;
    rx_wr_en        = 1'b0;
    rx_frame_active = 1'b0;
  endtask

  // Receiver write must appear on the RAM port one cycle later.
  task automatic chk_pass(input string tag);
    chk({tag, "_we"},      32'(ram_we),    32'(rx_wr_en));
    chk({tag, "_addr"},    32'(ram_addr),  32'(rx_wr_addr));
    chk({tag, "_din"},     ram_din,        rx_wr_data);
    chk({tag, "_loading"}, 32'(loading),   32'd0);
    chk({tag, "_done"},    32'(load_done), 32'd1);
    chk({tag, "_drop"},    32'(drop_cnt),  32'(m_drops));
  endtask

  // Preload: N writes then one closing cycle; stop < N+1 cuts it short.
  task automatic run_preload(input string tag, input bit rand_wr, input int stop);
    for (int i = 0; i < stop; i++) begin
      rx_wr_en        = rand_wr ? 1'($urandom_range(0, 1)) : 1'b0;
      rx_wr_addr      = 9'($urandom);
      rx_wr_data      = $urandom;
      rx_frame_active = 1'($urandom_range(0, 1));
      load_req        = 1'($urandom_range(0, 1));
      if (rx_wr_en && m_drops < 255) m_drops++;
      set_len_rand();
      tick_check($sformatf("%s%0d", tag, i));
      if (i < N) begin
        chk($sformatf("%s_we%0d", tag, i),      32'(ram_we),    32'd1);
        chk($sformatf("%s_addr%0d", tag, i),    32'(ram_addr),  32'(BASE + i));
        chk($sformatf("%s_din%0d", tag, i),     ram_din,        exp_words[i]);
        chk($sformatf("%s_loading%0d", tag, i), 32'(loading),   32'd1);
        chk($sformatf("%s_done%0d", tag, i),    32'(load_done), 32'(m_done));
      end else begin
        m_done = 1'b1;
        chk($sformatf("%s_we_end", tag),      32'(ram_we),    32'd0);
        chk($sformatf("%s_loading_end", tag), 32'(loading),   32'd0);
        chk($sformatf("%s_done_end", tag),    32'(load_done), 32'd1);
      end
      chk($sformatf("%s_drop%0d", tag, i), 32'(drop_cnt), 32'(m_drops));
    end
    idle_inputs();
  endtask

  task automatic run_pass(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      rx_wr_en        = 1'($urandom_range(0, 1));
      rx_wr_addr      = 9'($urandom);
      rx_wr_data      = $urandom;
      rx_frame_active = 1'($urandom_range(0, 1));
      load_req        = 1'b0;
      set_len_rand();
      tick_check($sformatf("%s%0d", tag, i));
      chk_pass($sformatf("%s%0d", tag, i));
    end
    idle_inputs();
  endtask

  initial begin
    int saved_drops;
    reset_n    = 1'b0;
    b_reset_n  = 1'b0;
    b_load_req = 1'b0;
    b_wr_en    = 1'b1;
    load_req   = 1'b1;
    rx_wr_en   = 1'b1;
    rx_frame_active = 1'b0;
    rx_wr_addr = 9'h0;
    rx_wr_data = 32'h0;

    // Reset holds every output at its reset value.
    for (int i = 0; i < 3; i++) begin
      set_len_rand();
      tick_check($sformatf("rst%0d", i));
      chk("rst_we",       32'(ram_we),    32'd0);
      chk("rst_addr",     32'(ram_addr),  32'd0);
      chk("rst_din",      ram_din,        32'd0);
      chk("rst_loading",  32'(loading),   32'd0);
      chk("rst_done",     32'(load_done), 32'd0);
      chk("rst_drop",     32'(drop_cnt),  32'd0);
      chk("big_rst_we",   32'(b_ram_we),  32'd0);
      chk("big_rst_drop", 32'(b_drop_cnt), 32'd0);
      chk("big_rst_dlen", 32'(b_tx_data_length),  32'(BIG_DEF_DL));
      chk("big_rst_tlen", 32'(b_tx_total_length), 32'(BIG_DEF_TL));
    end
    b_wr_en = 1'b0;
    idle_inputs();

    // Boot preload.
    reset_n = 1'b1;
    run_preload("boot", 1'b1, N + 1);

    // Length echo, directed.
    data_receive = 1'b0;
    tick_check("len_def");
    chk("len_def_d", 32'(tx_data_length),  32'd28);
    chk("len_def_t", 32'(tx_total_length), 32'd48);
    data_receive    = 1'b1;
    rx_data_length  = 16'd100;
    rx_total_length = 16'd120;
    tick_check("len_echo");
    chk("len_echo_d", 32'(tx_data_length),  32'd100);
    chk("len_echo_t", 32'(tx_total_length), 32'd120);

    // Pass-through of receiver writes.
    run_pass("pass", 20);
    rx_wr_en   = 1'b1;
    rx_wr_addr = 9'h010;
    rx_wr_data = 32'hDEADBEEF;
    set_len_rand();
    tick_check("beef");
    chk("beef_we",   32'(ram_we),   32'd1);
    chk("beef_addr", 32'(ram_addr), 32'h10);
    chk("beef_din",  ram_din,       32'hDEADBEEF);
    rx_wr_en = 1'b0;
    set_len_rand();
    tick_check("beef_after");
    chk("beef_after_we", 32'(ram_we), 32'd0);

    // Reload request during a frame waits; writes keep flowing meanwhile.
    load_req        = 1'b1;
    rx_frame_active = 1'b1;
    rx_wr_en        = 1'($urandom_range(0, 1));
    rx_wr_addr      = 9'($urandom);
    rx_wr_data      = $urandom;
    set_len_rand();
    tick_check("wreq");
    chk_pass("wreq");
    for (int i = 0; i < 8; i++) begin
      load_req        = 1'($urandom_range(0, 1));
      rx_frame_active = 1'b1;
      rx_wr_en        = 1'($urandom_range(0, 1));
      rx_wr_addr      = 9'($urandom);
      rx_wr_data      = $urandom;
      set_len_rand();
      tick_check($sformatf("wait%0d", i));
      chk_pass($sformatf("wait%0d", i));
    end
    load_req        = 1'b0;
    rx_frame_active = 1'b0;
    rx_wr_en        = 1'b1;
    rx_wr_addr      = 9'($urandom);
    rx_wr_data      = $urandom;
    set_len_rand();
    tick_check("wait_wr");
    chk_pass("wait_wr");
    rx_wr_en = 1'b0;
    set_len_rand();
    tick_check("wait_exit");
    chk_pass("wait_exit");
    saved_drops = m_drops;
    run_preload("wreload", 1'b0, N + 1);
    chk("wreload_drop_same", 32'(drop_cnt), 32'(saved_drops));

    // Immediate reload from an idle receiver; requests during LOAD are ignored.
    load_req = 1'b1;
    set_len_rand();
    tick_check("ireq");
    chk("ireq_we", 32'(ram_we), 32'd0);
    run_preload("ireload", 1'b1, N + 1);
    run_pass("post", 6);

    // Reset at word 3 aborts the preload; it restarts from word 0.
    load_req = 1'b1;
    set_len_rand();
    tick_check("areq");
    run_preload("abort", 1'b1, 3);
    reset_n  = 1'b0;
    rx_wr_en = 1'b1;
    set_len_rand();
    tick_check("abort_rst");
    m_drops = 0;
    m_done  = 1'b0;
    chk("abort_we",      32'(ram_we),    32'd0);
    chk("abort_addr",    32'(ram_addr),  32'd0);
    chk("abort_din",     ram_din,        32'd0);
    chk("abort_loading", 32'(loading),   32'd0);
    chk("abort_done",    32'(load_done), 32'd0);
    chk("abort_drop",    32'(drop_cnt),  32'd0);
    reset_n = 1'b1;
    idle_inputs();
    run_preload("restart", 1'b1, N + 1);
    run_pass("restart_pass", 4);

    // 300-word preload with continuous receiver writes saturates drop_cnt.
    b_reset_n = 1'b1;
    for (int i = 0; i <= BIG_N; i++) begin
      b_wr_en    = 1'b1;
      rx_wr_addr = 9'($urandom);
      rx_wr_data = $urandom;
      set_len_rand();
      tick_check($sformatf("big%0d", i));
      if (i < BIG_N) begin
        chk($sformatf("big_we%0d", i),      32'(b_ram_we),   32'd1);
        chk($sformatf("big_addr%0d", i),    32'(b_ram_addr), 32'(1 + i));
        chk($sformatf("big_din%0d", i),     b_ram_din,       32'hC0DE0000 | 32'(i));
        chk($sformatf("big_loading%0d", i), 32'(b_loading),  32'd1);
        chk($sformatf("big_drop%0d", i),    32'(b_drop_cnt), 32'((i + 1 > 255) ? 255 : i + 1));
      end else begin
        chk("big_we_end",   32'(b_ram_we),    32'd0);
        chk("big_done_end", 32'(b_load_done), 32'd1);
        chk("big_drop_end", 32'(b_drop_cnt),  32'd255);
      end
    end
    rx_wr_addr = 9'h1A5;
    rx_wr_data = 32'h12345678;
    set_len_rand();
    tick_check("big_pass");
    chk("big_pass_we",   32'(b_ram_we),   32'd1);
    chk("big_pass_addr", 32'(b_ram_addr), 32'h1A5);
    chk("big_pass_din",  b_ram_din,       32'h12345678);
    chk("big_pass_drop", 32'(b_drop_cnt), 32'd255);
    b_wr_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
